// File: rtl/somador_serial.sv
// -----------------------------------------------------------------------------
// somador_serial
// Bit-serial adder: S = A + B + CarryIn (mod 2^WIDTH) and the final carry.
// One result bit is produced per clock, LSB first, from a single full adder.
//
// Timing, with start accepted at edge N:
//   - SHIFT during the cycles after edges N .. N+WIDTH-1 (busy high WIDTH cycles)
//   - S / CarryOut loaded at edge N+WIDTH, FSM enters DONE
//   - done pulses in the cycle following edge N+WIDTH+1 (FSM back in IDLE)
//   - a held start is re-accepted at edge N+WIDTH+2 (period WIDTH+2)
//
// Optional feature:
//   SOMADOR_SERIAL_OVERFLOW_EN  adds output Overflow, the signed two's-complement
//                               overflow flag (carry into MSB XOR CarryOut),
//                               registered together with S.
// -----------------------------------------------------------------------------
module somador_serial #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CarryIn,
   output logic [WIDTH-1:0] S,
   output logic             CarryOut,
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
   output logic             Overflow,
`endif
   output logic             busy,
   output logic             done
);

   // Counter wide enough to hold 0 .. WIDTH
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   // Full-adder sum bit
   function automatic logic fa_sum(input logic a, input logic b, input logic c);
      return a ^ b ^ c;
   endfunction

   // Full-adder carry bit (majority of the three inputs)
   function automatic logic fa_carry(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // FSM state
   state_t state_r;
   state_t state_s;

   // Datapath registers and their next values
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] a_s;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] b_s;
   logic [WIDTH-1:0] res_r;
   logic [WIDTH-1:0] res_s;
   logic             c_r;
   logic             c_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;

   // Output registers and their next values
   logic [WIDTH-1:0] s_r;
   logic [WIDTH-1:0] s_s;
   logic             carry_out_r;
   logic             carry_out_s;
   logic             busy_r;
   logic             done_r;
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
   logic             ovf_r;
   logic             ovf_s;
`endif

   // Single full adder working on the current LSBs and the running carry
   logic             bit_sum_s;
   logic             bit_carry_s;
   logic             last_s;
   logic [WIDTH-1:0] res_shift_s;

   assign bit_sum_s   = fa_sum(a_r[0], b_r[0], c_r);
   assign bit_carry_s = fa_carry(a_r[0], b_r[0], c_r);
   assign last_s      = (cnt_r == LAST_CNT);
   assign res_shift_s = {bit_sum_s, res_r[WIDTH-1:1]};

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and datapath next values; everything holds unless the state says otherwise
   always_comb begin
      state_s     = state_r;
      a_s         = a_r;
      b_s         = b_r;
      c_s         = c_r;
      res_s       = res_r;
      cnt_s       = cnt_r;
      s_s         = s_r;
      carry_out_s = carry_out_r;
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
      ovf_s       = ovf_r;
`endif
      case (state_r)
         IDLE: begin
            if (start) begin
               a_s     = A;
               b_s     = B;
               c_s     = CarryIn;
               res_s   = DATA_ZERO;
               cnt_s   = CNT_ZERO;
               state_s = SHIFT;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            res_s = res_shift_s;
            a_s   = {1'b0, a_r[WIDTH-1:1]};
            b_s   = {1'b0, b_r[WIDTH-1:1]};
            c_s   = bit_carry_s;
            cnt_s = cnt_r + CNT_ONE;
            if (last_s) begin
               // Publish the full result only once the MSB is known
               s_s         = res_shift_s;
               carry_out_s = bit_carry_s;
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
               // c_r is the carry into the MSB at this point
               ovf_s       = c_r ^ bit_carry_s;
`endif
               state_s     = DONE;
            end else begin
               state_s = SHIFT;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Operand shift registers, carry flip-flop, bit counter and partial result
   always_ff @(posedge clk) begin
      if (reset) begin
         a_r   <= DATA_ZERO;
         b_r   <= DATA_ZERO;
         c_r   <= 1'b0;
         res_r <= DATA_ZERO;
         cnt_r <= CNT_ZERO;
      end else begin
         a_r   <= a_s;
         b_r   <= b_s;
         c_r   <= c_s;
         res_r <= res_s;
         cnt_r <= cnt_s;
      end
   end

   // Registered result, status and completion pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         s_r         <= DATA_ZERO;
         carry_out_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         s_r         <= s_s;
         carry_out_r <= carry_out_s;
         busy_r      <= (state_s == SHIFT);
         done_r      <= (state_r == DONE);
      end
   end

`ifdef SOMADOR_SERIAL_OVERFLOW_EN
   // Signed overflow flag, updated together with S
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_r <= 1'b0;
      end else begin
         ovf_r <= ovf_s;
      end
   end

   assign Overflow = ovf_r;
`endif

   assign S        = s_r;
   assign CarryOut = carry_out_r;
   assign busy     = busy_r;
   assign done     = done_r;

endmodule
